// File: rtl/bist_session_sequencer_if.sv
// Control/status bundle between a BIST session sequencer and its requester.
// The requester raises start/abort; the sequencer returns status and results.
interface bist_session_sequencer_if #(
    parameter int unsigned SIG_WIDTH = 4
);
    logic                 start;
    logic                 abort;
    logic                 busy;
    logic                 done;
    logic                 aborted;
    logic                 result_valid;
    logic                 pass;
    logic                 fail;
    logic [SIG_WIDTH-1:0] signature;
    logic [7:0]           session_count;
    logic [7:0]           fail_count;

    modport master (
        output start,
        output abort,
        input  busy,
        input  done,
        input  aborted,
        input  result_valid,
        input  pass,
        input  fail,
        input  signature,
        input  session_count,
        input  fail_count
    );

    modport slave (
        input  start,
        input  abort,
        output busy,
        output done,
        output aborted,
        output result_valid,
        output pass,
        output fail,
        output signature,
        output session_count,
        output fail_count
    );
endinterface

// File: rtl/bist_session_sequencer.sv
// Runs one BIST session: holds LFSR/MISR in reset, releases them for
// PATTERN_COUNT cycles, captures and grades the MISR signature.
module bist_session_sequencer #(
    parameter int unsigned          PATTERN_COUNT = 7,
    parameter int unsigned          SIG_WIDTH     = 4,
    parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG    = 4'b0011
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [SIG_WIDTH-1:0] misr_signature,
    output logic                 testmode,
    output logic                 tpg_reset,
    output logic                 ora_reset,
    bist_session_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [7:0] LAST_PATTERN = 8'(PATTERN_COUNT - 1);

    state_t               state_q;
    state_t               state_d;
    logic [7:0]           cnt_q;
    logic [7:0]           cnt_d;
    logic                 busy_q;
    logic                 busy_d;
    logic                 done_q;
    logic                 done_d;
    logic                 aborted_q;
    logic                 aborted_d;
    logic                 rv_q;
    logic                 rv_d;
    logic                 pass_q;
    logic                 pass_d;
    logic                 fail_q;
    logic                 fail_d;
    logic [SIG_WIDTH-1:0] sig_q;
    logic [SIG_WIDTH-1:0] sig_d;
    logic [7:0]           sc_q;
    logic [7:0]           sc_d;
    logic [7:0]           fc_q;
    logic [7:0]           fc_d;
    logic                 testmode_d;
    logic                 sub_reset_d;
    logic                 in_session;
    logic                 match;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign in_session = (state_q == INIT) || (state_q == RUN) ||
                        (state_q == CAPTURE);
    assign match      = (misr_signature == GOLDEN_SIG);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            testmode  <= 1'b0;
            tpg_reset <= 1'b1;
            ora_reset <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            rv_q      <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            sig_q     <= '0;
            sc_q      <= '0;
            fc_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            testmode  <= testmode_d;
            tpg_reset <= sub_reset_d;
            ora_reset <= sub_reset_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            rv_q      <= rv_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            sig_q     <= sig_d;
            sc_q      <= sc_d;
            fc_q      <= fc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        rv_d      = rv_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        sig_d     = sig_q;
        sc_d      = sc_q;
        fc_d      = fc_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = INIT;
                    rv_d    = 1'b0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                end
            end
            INIT: begin
                state_d = RUN;
                cnt_d   = '0;
            end
            RUN: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == LAST_PATTERN) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                // MISR reset only lands on this edge, so the value is final
                state_d = DONE;
                done_d  = 1'b1;
                sig_d   = misr_signature;
                pass_d  = match;
                fail_d  = !match;
                rv_d    = 1'b1;
                sc_d    = sat_inc(sc_q);
                if (!match) begin
                    fc_d = sat_inc(fc_q);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.abort && in_session) begin
            state_d   = IDLE;
            cnt_d     = cnt_q;
            done_d    = 1'b0;
            aborted_d = 1'b1;
            rv_d      = 1'b0;
            pass_d    = 1'b0;
            fail_d    = 1'b0;
            sig_d     = sig_q;
            sc_d      = sc_q;
            fc_d      = fc_q;
        end

        testmode_d  = (state_d != IDLE);
        sub_reset_d = (state_d != RUN);
        busy_d      = (state_d == INIT) || (state_d == RUN) ||
                      (state_d == CAPTURE);
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.aborted       = aborted_q;
    assign bus.result_valid  = rv_q;
    assign bus.pass          = pass_q;
    assign bus.fail          = fail_q;
    assign bus.signature     = sig_q;
    assign bus.session_count = sc_q;
    assign bus.fail_count    = fc_q;

endmodule

// File: tb/tb_bist_session_sequencer.sv
// Bench for bist_session_sequencer: fixed vector table, directed corner
// sequences and random traffic graded by a timeline-based reference model.
module tb_bist_session_sequencer;

    localparam int          P    = 7;
    localparam logic [3:0]  GOLD = 4'b0011;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] misr  = 4'd0;
    logic       testmode;
    logic       tpg_reset;
    logic       ora_reset;

    bist_session_sequencer_if #(.SIG_WIDTH(4)) bus ();

    bist_session_sequencer #(
        .PATTERN_COUNT(P),
        .SIG_WIDTH(4),
        .GOLDEN_SIG(GOLD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .misr_signature(misr),
        .testmode(testmode),
        .tpg_reset(tpg_reset),
        .ora_reset(ora_reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit         rst;
        bit         st;
        bit         ab;
        logic [3:0] m;
        bit         tm;
        bit         tpg;
        bit         busy;
        bit         done;
        bit         abd;
        bit         rv;
        bit         ps;
        bit         fl;
        logic [3:0] sig;
        logic [7:0] sc;
        logic [7:0] fc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit rst, bit st, bit ab, logic [3:0] m,
                                bit tm, bit tpg, bit busy, bit done,
                                bit abd, bit rv, bit ps, bit fl,
                                logic [3:0] sig, logic [7:0] sc,
                                logic [7:0] fc);
        vec_t v;
        v.rst = rst; v.st = st; v.ab = ab; v.m = m;
        v.tm = tm; v.tpg = tpg; v.busy = busy; v.done = done;
        v.abd = abd; v.rv = rv; v.ps = ps; v.fl = fl;
        v.sig = sig; v.sc = sc; v.fc = fc;
        vecs.push_back(v);
    endfunction

    // Reference model: position within a session timeline, -1 when idle.
    // 0 = setup cycle, 1..P = pattern cycles, P+1 = capture, P+2 = done.
    int         pos;
    bit         m_done;
    bit         m_ab;
    bit         m_rv;
    bit         m_pass;
    bit         m_fail;
    logic [3:0] m_sig;
    int         m_sc;
    int         m_fc;

    function automatic void model_edge(bit r, bit s, bit a, logic [3:0] m);
        m_done = 0;
        m_ab   = 0;
        if (r) begin
            pos = -1; m_rv = 0; m_pass = 0; m_fail = 0;
            m_sig = 0; m_sc = 0; m_fc = 0;
        end else if (pos < 0) begin
            if (s && !a) begin
                pos = 0; m_rv = 0; m_pass = 0; m_fail = 0;
            end
        end else if (pos <= P + 1 && a) begin
            pos = -1; m_ab = 1; m_rv = 0; m_pass = 0; m_fail = 0;
        end else if (pos == P + 1) begin
            m_sig  = m;
            m_pass = (m == GOLD);
            m_fail = (m != GOLD);
            m_rv   = 1;
            m_sc   = (m_sc < 255) ? m_sc + 1 : 255;
            if (m != GOLD) m_fc = (m_fc < 255) ? m_fc + 1 : 255;
            m_done = 1;
            pos    = P + 2;
        end else if (pos == P + 2) begin
            pos = -1;
        end else begin
            pos++;
        end
    endfunction

    task automatic step(bit r, bit s, bit a, logic [3:0] m);
        bit in_run;
        reset = r; bus.start = s; bus.abort = a; misr = m;
        @(posedge clock);
        model_edge(r, s, a, m);
        #1;
        in_run = (pos >= 1 && pos <= P);
        chk("testmode", testmode, 32'(pos >= 0));
        chk("tpg_reset", tpg_reset, 32'(!in_run));
        chk("ora_reset", ora_reset, 32'(!in_run));
        chk("busy", bus.busy, 32'(pos >= 0 && pos <= P + 1));
        chk("done", bus.done, 32'(m_done));
        chk("aborted", bus.aborted, 32'(m_ab));
        chk("result_valid", bus.result_valid, 32'(m_rv));
        chk("pass", bus.pass, 32'(m_pass));
        chk("fail", bus.fail, 32'(m_fail));
        chk("signature", bus.signature, 32'(m_sig));
        chk("session_count", bus.session_count, 32'(m_sc));
        chk("fail_count", bus.fail_count, 32'(m_fc));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int low_cnt;
        int done_at[$];
        int cyc;
        bus.start = 0;
        bus.abort = 0;

        // Good session, start ignored in DONE, then a faulty session.
        add(1,0,0,3, 0,1,0,0,0, 0,0,0,0,0,0);
        add(0,1,0,3, 1,1,1,0,0, 0,0,0,0,0,0);
        for (int i = 0; i < P; i++)
            add(0,0,0,3, 1,0,1,0,0, 0,0,0,0,0,0);
        add(0,0,0,3, 1,1,1,0,0, 0,0,0,0,0,0);
        add(0,1,0,3, 1,1,0,1,0, 1,1,0,3,1,0);
        add(0,0,0,3, 0,1,0,0,0, 1,1,0,3,1,0);
        add(1,0,0,5, 0,1,0,0,0, 0,0,0,0,0,0);
        add(0,1,0,5, 1,1,1,0,0, 0,0,0,0,0,0);
        for (int i = 0; i < P; i++)
            add(0,0,0,5, 1,0,1,0,0, 0,0,0,0,0,0);
        add(0,0,0,5, 1,1,1,0,0, 0,0,0,0,0,0);
        add(0,0,0,5, 1,1,0,1,0, 1,0,1,5,1,1);
        add(0,0,0,5, 0,1,0,0,0, 1,0,1,5,1,1);
        add(0,1,1,5, 0,1,0,0,0, 1,0,1,5,1,1);
        add(0,0,0,5, 0,1,0,0,0, 1,0,1,5,1,1);

        foreach (vecs[i]) begin
            reset = vecs[i].rst; bus.start = vecs[i].st;
            bus.abort = vecs[i].ab; misr = vecs[i].m;
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d_testmode", i), testmode, 32'(vecs[i].tm));
            chk($sformatf("vec%0d_tpg", i), tpg_reset, 32'(vecs[i].tpg));
            chk($sformatf("vec%0d_ora", i), ora_reset, 32'(vecs[i].tpg));
            chk($sformatf("vec%0d_busy", i), bus.busy, 32'(vecs[i].busy));
            chk($sformatf("vec%0d_done", i), bus.done, 32'(vecs[i].done));
            chk($sformatf("vec%0d_aborted", i), bus.aborted, 32'(vecs[i].abd));
            chk($sformatf("vec%0d_rv", i), bus.result_valid, 32'(vecs[i].rv));
            chk($sformatf("vec%0d_pass", i), bus.pass, 32'(vecs[i].ps));
            chk($sformatf("vec%0d_fail", i), bus.fail, 32'(vecs[i].fl));
            chk($sformatf("vec%0d_sig", i), bus.signature, 32'(vecs[i].sig));
            chk($sformatf("vec%0d_sc", i), bus.session_count, 32'(vecs[i].sc));
            chk($sformatf("vec%0d_fc", i), bus.fail_count, 32'(vecs[i].fc));
        end

        // Pattern window length: resets low for exactly P cycles.
        step(1, 0, 0, GOLD);
        step(0, 1, 0, GOLD);
        low_cnt = 0;
        for (int i = 0; i < P + 3; i++) begin
            step(0, 0, 0, GOLD);
            if (!tpg_reset) low_cnt++;
        end
        chk("tpg_low_cycles", 32'(low_cnt), 32'(P));

        // Abort in the third pattern cycle, then a clean session.
        step(1, 0, 0, GOLD);
        step(0, 1, 0, GOLD);
        for (int i = 0; i < 3; i++) step(0, 0, 0, GOLD);
        step(0, 0, 1, GOLD);
        chk("abort_pulse", bus.aborted, 1);
        chk("abort_testmode", testmode, 0);
        chk("abort_tpg", tpg_reset, 1);
        chk("abort_rv", bus.result_valid, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, GOLD);
            chk("abort_no_done", bus.done, 0);
        end
        chk("abort_sc", bus.session_count, 0);
        step(0, 1, 0, GOLD);
        for (int i = 0; i < P + 2; i++) step(0, 0, 0, GOLD);
        chk("after_abort_done", bus.done, 1);
        chk("after_abort_pass", bus.pass, 1);
        chk("after_abort_sc", bus.session_count, 1);

        // start held high: sessions every P+4 cycles.
        step(1, 0, 0, GOLD);
        for (cyc = 0; cyc < 5 * (P + 4); cyc++) begin
            step(0, 1, 0, GOLD);
            if (bus.done) done_at.push_back(cyc);
        end
        chk("held_sessions", 32'(done_at.size()), 32'(5));
        for (int i = 1; i < done_at.size(); i++)
            chk("held_period", 32'(done_at[i] - done_at[i-1]), 32'(P + 4));

        // Reset during capture after one finished session.
        step(1, 0, 0, GOLD);
        step(0, 1, 0, GOLD);
        for (int i = 0; i < P + 3; i++) step(0, 0, 0, GOLD);
        step(0, 1, 0, GOLD);
        for (int i = 0; i < P + 1; i++) step(0, 0, 0, GOLD);
        chk("cap_busy", bus.busy, 1);
        step(1, 0, 0, GOLD);
        chk("rst_cap_done", bus.done, 0);
        chk("rst_cap_sc", bus.session_count, 0);
        chk("rst_cap_testmode", testmode, 0);
        step(0, 0, 0, GOLD);
        chk("rst_cap_done2", bus.done, 0);

        // 257 failing sessions saturate both counters.
        step(1, 0, 0, GOLD);
        for (int i = 0; i < 257 * (P + 4); i++) step(0, 1, 0, 4'b0101);
        step(0, 0, 0, 4'b0101);
        chk("sat_sc", bus.session_count, 255);
        chk("sat_fc", bus.fail_count, 255);

        // Random traffic against the model.
        step(1, 0, 0, GOLD);
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] m;
            m = ($urandom_range(1) == 0) ? GOLD : 4'($urandom);
            step($urandom_range(199) == 0, $urandom_range(2) == 0,
                 $urandom_range(19) == 0, m);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
